// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding and the bubble payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned STAGE_W = 32;

  // NOP instruction used as the bubble between stages
  localparam logic [STAGE_W-1:0] NOP_BUBBLE = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones. Cleared only by async clr.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter bit                   SKID      = 1'b1,
  parameter logic [WIDTH-1:0]     FLUSH_VAL = WIDTH'(NOP_BUBBLE),
  parameter int unsigned          STALL_W   = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  assign w_out_valid = (r_state != EMPTY);

  // With a skid entry, ready depends on state only; without, it looks through to out_ready
  generate
    if (SKID) begin : g_skid
      assign w_in_ready = (r_state != TWO);
    end else begin : g_single
      assign w_in_ready = !w_out_valid || out_ready;
    end
  endgenerate

  assign w_push = in_valid && w_in_ready;
  assign w_pop  = w_out_valid && out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= EMPTY;
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = FLUSH_VAL;
      w_skid_nxt  = FLUSH_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            if (SKID) begin
              w_state_nxt = TWO;
              w_skid_nxt  = in_data;
            end
          end else if (w_pop && !w_push) begin
            w_state_nxt = EMPTY;
          end else if (w_pop && w_push) begin
            w_main_nxt = in_data;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (w_out_valid && !out_ready),
    .count (stall_count)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid stage (A), single-entry stage (B), 3-bit stall counter stage (C).
module tb_pipe_stage_reg;

  localparam logic [31:0] FV_A = 32'hFFFF_0013;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [31:0] a_stall;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [31:0] b_stall;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;
  logic [2:0]  c_stall;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .FLUSH_VAL(FV_A), .STALL_W(32)) u_a (
    .clk(clk), .clr(clr), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .flush(a_flush),
    .occupancy(a_occ), .stall_count(a_stall)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .FLUSH_VAL(32'h0), .STALL_W(32)) u_b (
    .clk(clk), .clr(clr), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .flush(b_flush),
    .occupancy(b_occ), .stall_count(b_stall)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .FLUSH_VAL(32'h0), .STALL_W(3)) u_c (
    .clk(clk), .clr(clr), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .flush(c_flush),
    .occupancy(c_occ), .stall_count(c_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    {a_in_valid, a_out_ready, a_flush, a_in_data} = '0;
    {b_in_valid, b_out_ready, b_flush, b_in_data} = '0;
    {c_in_valid, c_out_ready, c_flush, c_in_data} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_data",  64'(a_out_data),  64'(FV_A));
    chk("rst_a_occ",   64'(a_occ),       64'd0);
    chk("rst_a_stall", 64'(a_stall),     64'd0);
    chk("rst_a_ready", 64'(a_in_ready),  64'd1);
    chk("rst_b_data",  64'(b_out_data),  64'd0);
    clr = 1'b0;

    // A: streaming with out_ready=1
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_in_data = 32'h11; step();
    chk("str_v1",   64'(a_out_valid), 64'd1);
    chk("str_d1",   64'(a_out_data),  64'h11);
    chk("str_occ1", 64'(a_occ),       64'd1);
    a_in_data = 32'h22; step();
    chk("str_d2",   64'(a_out_data),  64'h22);
    a_in_data = 32'h33; step();
    chk("str_d3",   64'(a_out_data),  64'h33);
    chk("str_occ3", 64'(a_occ),       64'd1);
    a_in_valid = 1'b0; step();
    chk("str_drain_v", 64'(a_out_valid), 64'd0);
    chk("str_keep_d",  64'(a_out_data),  64'h33);
    chk("str_stall",   64'(a_stall),     64'd0);

    // A: skid absorbs one item after back-pressure
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 32'hA; step();
    chk("skd_occA", 64'(a_occ),      64'd1);
    chk("skd_rdyA", 64'(a_in_ready), 64'd1);
    a_in_data = 32'hB; step();
    chk("skd_occB", 64'(a_occ),      64'd2);
    chk("skd_rdyB", 64'(a_in_ready), 64'd0);
    chk("skd_dB",   64'(a_out_data), 64'hA);
    a_in_data = 32'hC; step();
    chk("skd_occC",  64'(a_occ),     64'd2);
    chk("skd_stall", 64'(a_stall),   64'd2);
    a_out_ready = 1'b1;
    #1;
    chk("skd_out0", 64'(a_out_data), 64'hA);
    step();
    chk("skd_out1", 64'(a_out_data), 64'hB);
    chk("skd_occ1", 64'(a_occ),      64'd1);
    chk("skd_rdy1", 64'(a_in_ready), 64'd1);
    step();
    chk("skd_out2", 64'(a_out_data), 64'hC);
    a_in_valid = 1'b0; step();
    chk("skd_empty",  64'(a_out_valid), 64'd0);
    chk("skd_stall2", 64'(a_stall),     64'd2);

    // A: flush in TWO with a simultaneous push and pop
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 32'hD; step();
    a_in_data = 32'hE; step();
    chk("fl_occ2",   64'(a_occ),   64'd2);
    chk("fl_stall0", 64'(a_stall), 64'd3);
    a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 32'hF; step();
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_data",  64'(a_out_data),  64'(FV_A));
    chk("fl_occ",   64'(a_occ),       64'd0);
    chk("fl_stall", 64'(a_stall),     64'd3);
    a_flush = 1'b0; a_in_valid = 1'b0; step();
    chk("fl_absent", 64'(a_out_valid), 64'd0);

    // A: async clear between edges while holding one item
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h5A; step();
    a_in_valid = 1'b0;
    chk("ac_pre_occ", 64'(a_occ), 64'd1);
    #3 clr = 1'b1;
    #1;
    chk("ac_valid", 64'(a_out_valid), 64'd0);
    chk("ac_occ",   64'(a_occ),       64'd0);
    chk("ac_data",  64'(a_out_data),  64'(FV_A));
    chk("ac_stall", 64'(a_stall),     64'd0);
    chk("ac_ready", 64'(a_in_ready),  64'd1);
    #1 clr = 1'b0;

    // B: single entry, combinational ready
    b_in_valid = 1'b1; b_in_data = 32'h55; b_out_ready = 1'b0;
    #1;
    chk("b_rdy_empty", 64'(b_in_ready), 64'd1);
    step();
    b_in_valid = 1'b0;
    chk("b_d55", 64'(b_out_data), 64'h55);
    repeat (5) step();
    chk("b_rdy_stall", 64'(b_in_ready), 64'd0);
    chk("b_stall5",    64'(b_stall),    64'd5);
    chk("b_occ1",      64'(b_occ),      64'd1);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 32'h66;
    #1;
    chk("b_rdy_thru", 64'(b_in_ready), 64'd1);
    step();
    chk("b_d66",    64'(b_out_data), 64'h66);
    chk("b_occ_pp", 64'(b_occ),      64'd1);
    chk("b_stall_h", 64'(b_stall),   64'd5);
    b_in_valid = 1'b0; step();
    chk("b_empty", 64'(b_out_valid), 64'd0);

    // C: 3-bit stall counter saturates at 7
    c_in_valid = 1'b1; c_in_data = 32'h99; c_out_ready = 1'b0; step();
    c_in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("c_sat%0d", k), 64'(c_stall), 64'((k > 7) ? 7 : k));
    end
    chk("c_data", 64'(c_out_data), 64'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
